// File: rtl/peripheral_bfm_slave_axi4.sv
// Single-beat AXI4 slave with a small register file.
// Configurable response latency and optional SLVERR on out-of-range.
module peripheral_bfm_slave_axi4 #(
  parameter int MEM_WORDS   = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int ERR_EN      = 1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  awid,
  input  logic [31:0] awadr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wrdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int LP_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] LP_WEND =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;

  typedef enum logic [2:0] {
    W_IDLE, W_ADDR, W_DATA, W_WAIT, W_RESP
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE, R_WAIT, R_RESP
  } rstate_t;

  function automatic logic [LP_AW-1:0] f_idx(input logic [31:0] a);
    return a[LP_AW+1:2];
  endfunction

  function automatic logic f_err(input logic [31:0] a);
    return (ERR_EN != 0) && (|a[31:LP_AW+2]);
  endfunction

  logic [31:0] r_mem [MEM_WORDS];
  logic        r_live;

  wstate_t     r_wstate;
  wstate_t     w_wnext;
  logic [31:0] r_awadr;
  logic [3:0]  r_awid;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_wcnt;

  rstate_t     r_rstate;
  rstate_t     w_rnext;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [3:0]  r_rcnt;

  logic        w_awready;
  logic        w_wready;
  logic        w_arready;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  logic        w_bvalid;
  logic        w_rvalid;

  logic [31:0] w_wa;
  logic [31:0] w_wd;
  logic [3:0]  w_ws;
  logic [3:0]  w_wid;
  logic        w_werr;
  logic [LP_AW-1:0] w_widx;
  logic        w_rerr;
  logic [LP_AW-1:0] w_ridx;

  logic        w_unused_ok;
  assign w_unused_ok = wlast;

  assign w_awready = r_live &
    ((r_wstate == W_IDLE) || (r_wstate == W_DATA));
  assign w_wready  = r_live &
    ((r_wstate == W_IDLE) || (r_wstate == W_ADDR));
  assign w_arready = r_live & (r_rstate == R_IDLE);

  assign w_aw_hs = awvalid & w_awready;
  assign w_w_hs  = wvalid & w_wready;
  assign w_ar_hs = arvalid & w_arready;

  // Merge the held half of a split write with the live half.
  assign w_wa  = (r_wstate == W_ADDR) ? r_awadr : awadr;
  assign w_wid = (r_wstate == W_ADDR) ? r_awid  : awid;
  assign w_wd  = (r_wstate == W_DATA) ? r_wdata : wrdata;
  assign w_ws  = (r_wstate == W_DATA) ? r_wstrb : wstrb;
  assign w_werr = f_err(w_wa);
  assign w_widx = f_idx(w_wa);
  assign w_rerr = f_err(araddr);
  assign w_ridx = f_idx(araddr);

  // Readies only come up one edge after reset is released.
  always_ff @(posedge aclk) begin
    r_live <= ~areset;
  end

  // Write FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) r_wstate <= W_IDLE;
    else        r_wstate <= w_wnext;
  end

  // Write FSM next state, commit strobe and bvalid.
  always_comb begin
    w_wnext  = r_wstate;
    w_commit = 1'b0;
    w_bvalid = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_commit = 1'b1;
        else if (w_aw_hs)      w_wnext  = W_ADDR;
        else if (w_w_hs)       w_wnext  = W_DATA;
      end
      W_ADDR: begin
        if (w_w_hs) w_commit = 1'b1;
      end
      W_DATA: begin
        if (w_aw_hs) w_commit = 1'b1;
      end
      W_WAIT: begin
        if (r_wcnt == LP_WEND) w_wnext = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (bready) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
    if (w_commit)
      w_wnext = (WAIT_CYCLES == 0) ? W_RESP : W_WAIT;
  end

  // Write channel holding registers, response fields, wait counter.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_awadr <= '0;
      r_awid  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_bid   <= '0;
      r_bresp <= RESP_OK;
      r_wcnt  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_awadr <= awadr;
        r_awid  <= awid;
      end
      if (w_w_hs) begin
        r_wdata <= wrdata;
        r_wstrb <= wstrb;
      end
      if (w_commit) begin
        r_bid   <= w_wid;
        r_bresp <= w_werr ? RESP_ERR : RESP_OK;
        r_wcnt  <= '0;
      end else if (r_wstate == W_WAIT) begin
        r_wcnt  <= r_wcnt + 4'd1;
      end
    end
  end

  // Register file: byte-lane writes; errored writes leave it alone.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
    end else if (w_commit && !w_werr) begin
      for (int b = 0; b < 4; b++)
        if (w_ws[b]) r_mem[w_widx][8*b +: 8] <= w_wd[8*b +: 8];
    end
  end

  // Read FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) r_rstate <= R_IDLE;
    else        r_rstate <= w_rnext;
  end

  // Read FSM next state and rvalid.
  always_comb begin
    w_rnext  = r_rstate;
    w_rvalid = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs)
          w_rnext = (WAIT_CYCLES == 0) ? R_RESP : R_WAIT;
      end
      R_WAIT: begin
        if (r_rcnt == LP_WEND) w_rnext = R_RESP;
      end
      R_RESP: begin
        w_rvalid = 1'b1;
        if (rready) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read capture: memory sampled at the AR edge sees pre-write data.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rid   <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OK;
      r_rcnt  <= '0;
    end else if (w_ar_hs) begin
      r_rid   <= arid;
      r_rdata <= w_rerr ? 32'h0 : r_mem[w_ridx];
      r_rresp <= w_rerr ? RESP_ERR : RESP_OK;
      r_rcnt  <= '0;
    end else if (r_rstate == R_WAIT) begin
      r_rcnt  <= r_rcnt + 4'd1;
    end
  end

  assign awready = w_awready;
  assign wready  = w_wready;
  assign arready = w_arready;
  assign bvalid  = w_bvalid;
  assign bid     = r_bid;
  assign bresp   = r_bresp;
  assign rvalid  = w_rvalid;
  assign rlast   = w_rvalid;
  assign rid     = r_rid;
  assign rresp   = r_rresp;
  assign rdata   = w_rvalid ? r_rdata : 32'h0;

endmodule

// File: tb/tb_peripheral_bfm_slave_axi4.sv
// Directed bench for peripheral_bfm_slave_axi4.
// u_dut0: defaults; u_dut1: WAIT_CYCLES=3, ERR_EN=0.
module tb_peripheral_bfm_slave_axi4;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  logic [3:0]  awid = '0;
  logic [31:0] awadr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wrdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;

  logic [3:0]  b_awid = '0;
  logic [31:0] b_awadr = '0;
  logic        b_awvalid = 1'b0;
  logic        b_awready;
  logic [31:0] b_wrdata = '0;
  logic [3:0]  b_wstrb = '0;
  logic        b_wlast = 1'b0;
  logic        b_wvalid = 1'b0;
  logic        b_wready;
  logic [3:0]  b_bid;
  logic [1:0]  b_bresp;
  logic        b_bvalid;
  logic        b_bready = 1'b0;
  logic [3:0]  b_arid = '0;
  logic [31:0] b_araddr = '0;
  logic        b_arvalid = 1'b0;
  logic        b_arready;
  logic [3:0]  b_rid;
  logic [31:0] b_rdata;
  logic [1:0]  b_rresp;
  logic        b_rlast;
  logic        b_rvalid;
  logic        b_rready = 1'b0;

  int checks = 0;
  int errors = 0;

  peripheral_bfm_slave_axi4 u_dut0 (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awadr(awadr), .awvalid(awvalid), .awready(awready),
    .wrdata(wrdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .arid(arid), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  peripheral_bfm_slave_axi4 #(
    .MEM_WORDS(16), .WAIT_CYCLES(3), .ERR_EN(0)
  ) u_dut1 (
    .aclk(aclk), .areset(areset),
    .awid(b_awid), .awadr(b_awadr), .awvalid(b_awvalid),
    .awready(b_awready), .wrdata(b_wrdata), .wstrb(b_wstrb),
    .wlast(b_wlast), .wvalid(b_wvalid), .wready(b_wready),
    .bid(b_bid), .bresp(b_bresp), .bvalid(b_bvalid), .bready(b_bready),
    .arid(b_arid), .araddr(b_araddr), .arvalid(b_arvalid),
    .arready(b_arready), .rid(b_rid), .rdata(b_rdata), .rresp(b_rresp),
    .rlast(b_rlast), .rvalid(b_rvalid), .rready(b_rready)
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  // Address and data presented together on u_dut0.
  task automatic axi_write(
    input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] s, input logic [3:0] id,
    output logic [3:0] ob, output logic [1:0] orsp, output int lat);
    awadr = a; awid = id; awvalid = 1'b1;
    wrdata = d; wstrb = s; wlast = 1'b1; wvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    lat = 1;
    while (bvalid !== 1'b1 && lat < 20) begin tick; lat++; end
    if (bvalid !== 1'b1) lat = -1;
    ob = bid; orsp = bresp;
    bready = 1'b1; tick; bready = 1'b0;
  endtask

  task automatic axi_read(
    input logic [31:0] a, input logic [3:0] id,
    output logic [31:0] od, output logic [1:0] orsp,
    output logic ol, output logic [3:0] oid, output int lat);
    araddr = a; arid = id; arvalid = 1'b1;
    tick;
    arvalid = 1'b0;
    lat = 1;
    while (rvalid !== 1'b1 && lat < 20) begin tick; lat++; end
    if (rvalid !== 1'b1) lat = -1;
    od = rdata; orsp = rresp; ol = rlast; oid = rid;
    rready = 1'b1; tick; rready = 1'b0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) tick;
    checks++;
    if ({awready, wready, arready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: got %b want 000",
               {awready, wready, arready});
    end
    checks++;
    if ({bvalid, rvalid, rlast, bresp, rresp, bid, rid} !== 15'h0) begin
      errors++;
      $display("FAIL reset_resp: got %h want 0",
               {bvalid, rvalid, rlast, bresp, rresp, bid, rid});
    end
    checks++;
    if (rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    areset = 1'b0;
    tick;
    checks++;
    if ({awready, wready, arready, b_awready} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_release: got %b want 1111",
               {awready, wready, arready, b_awready});
    end
  endtask

  task automatic test_aw_w_same;
    logic [3:0] ob; logic [1:0] orsp; int lat;
    logic [31:0] od; logic ol; logic [3:0] oid;
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 4'd3, ob, orsp, lat);
    checks++;
    if ({lat, ob, orsp} !== {32'd1, 4'd3, 2'b00}) begin
      errors++;
      $display("FAIL wr_same: got lat=%0d bid=%0d bresp=%b want 1 3 00",
               lat, ob, orsp);
    end
    axi_read(32'h8, 4'd5, od, orsp, ol, oid, lat);
    checks++;
    if ({lat, od, orsp, ol, oid} !==
        {32'd1, 32'hDEADBEEF, 2'b00, 1'b1, 4'd5}) begin
      errors++;
      $display("FAIL rd_same: got lat=%0d d=%h r=%b l=%b id=%0d want 1 deadbeef 00 1 5",
               lat, od, orsp, ol, oid);
    end
    checks++;
    if ({rvalid, rlast, rdata} !== 34'h0) begin
      errors++;
      $display("FAIL rd_idle: got v=%b l=%b d=%h want 0 0 0",
               rvalid, rlast, rdata);
    end
  endtask

  task automatic test_w_before_aw;
    logic [31:0] od; logic [1:0] orsp; logic ol; logic [3:0] oid; int lat;
    wrdata = 32'h11223344; wstrb = 4'b0101; wlast = 1'b1; wvalid = 1'b1;
    tick;
    wvalid = 1'b0; wlast = 1'b0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b100) begin
      errors++;
      $display("FAIL w_data_state: got %b want 100",
               {awready, wready, bvalid});
    end
    tick;
    awadr = 32'h8; awid = 4'd7; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd7, 2'b00}) begin
      errors++;
      $display("FAIL w_first_resp: got v=%b id=%0d r=%b want 1 7 00",
               bvalid, bid, bresp);
    end
    bready = 1'b1; tick; bready = 1'b0;
    axi_read(32'h8, 4'd1, od, orsp, ol, oid, lat);
    checks++;
    if (od !== 32'hDE22BE44) begin
      errors++; $display("FAIL strobe_merge: got %h want de22be44", od);
    end
  endtask

  task automatic test_aw_before_w;
    logic [31:0] od; logic [1:0] orsp; logic ol; logic [3:0] oid; int lat;
    awadr = 32'hC; awid = 4'd2; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b010) begin
      errors++;
      $display("FAIL w_addr_state: got %b want 010",
               {awready, wready, bvalid});
    end
    tick;
    wrdata = 32'hA5A51234; wstrb = 4'b1100; wvalid = 1'b1;
    tick;
    wvalid = 1'b0;
    checks++;
    if ({bvalid, bid, bresp} !== {1'b1, 4'd2, 2'b00}) begin
      errors++;
      $display("FAIL aw_first_resp: got v=%b id=%0d r=%b want 1 2 00",
               bvalid, bid, bresp);
    end
    bready = 1'b1; tick; bready = 1'b0;
    axi_read(32'hC, 4'd1, od, orsp, ol, oid, lat);
    checks++;
    if (od !== 32'hA5A50000) begin
      errors++; $display("FAIL aw_first_data: got %h want a5a50000", od);
    end
  endtask

  task automatic test_slverr;
    logic [3:0] ob; logic [1:0] orsp; int lat;
    logic [31:0] od; logic ol; logic [3:0] oid;
    axi_write(32'h0, 32'h12345678, 4'hF, 4'd4, ob, orsp, lat);
    axi_read(32'h40, 4'd6, od, orsp, ol, oid, lat);
    checks++;
    if ({od, orsp, ol, oid} !== {32'h0, 2'b10, 1'b1, 4'd6}) begin
      errors++;
      $display("FAIL rd_err: got d=%h r=%b l=%b id=%0d want 0 10 1 6",
               od, orsp, ol, oid);
    end
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 4'd8, ob, orsp, lat);
    checks++;
    if ({ob, orsp} !== {4'd8, 2'b10}) begin
      errors++;
      $display("FAIL wr_err: got id=%0d r=%b want 8 10", ob, orsp);
    end
    axi_read(32'h0, 4'd0, od, orsp, ol, oid, lat);
    checks++;
    if ({od, orsp} !== {32'h12345678, 2'b00}) begin
      errors++;
      $display("FAIL err_no_write: got %h/%b want 12345678/00", od, orsp);
    end
    axi_read(32'h80000008, 4'd0, od, orsp, ol, oid, lat);
    checks++;
    if ({od, orsp} !== {32'h0, 2'b10}) begin
      errors++;
      $display("FAIL rd_err_hi: got %h/%b want 0/10", od, orsp);
    end
  endtask

  task automatic test_same_cycle_rw;
    logic [31:0] od; logic [1:0] orsp; logic ol; logic [3:0] oid; int lat;
    awadr = 32'h8; awid = 4'd1; awvalid = 1'b1;
    wrdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h8; arid = 4'd2; arvalid = 1'b1;
    tick;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    checks++;
    if ({bvalid, rvalid, rdata} !== {1'b1, 1'b1, 32'hDE22BE44}) begin
      errors++;
      $display("FAIL rw_collide: got bv=%b rv=%b d=%h want 1 1 de22be44",
               bvalid, rvalid, rdata);
    end
    bready = 1'b1; rready = 1'b1; tick; bready = 1'b0; rready = 1'b0;
    axi_read(32'h8, 4'd0, od, orsp, ol, oid, lat);
    checks++;
    if (od !== 32'h0BADF00D) begin
      errors++; $display("FAIL rw_after: got %h want 0badf00d", od);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] ob; logic [1:0] orsp; int lat;
    araddr = 32'h0; arvalid = 1'b0;
    axi_write(32'h3C, 32'h0F0FF0F0, 4'hF, 4'd9, ob, orsp, lat);
    axi_write(32'h4, 32'h11111111, 4'hF, 4'd10, ob, orsp, lat);
    araddr = 32'h3C; arid = 4'd11; arvalid = 1'b1;
    tick;
    araddr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rvalid, arready, rid, rdata} !==
          {1'b1, 1'b0, 4'd11, 32'h0F0FF0F0}) begin
        errors++;
        $display("FAIL rd_stall%0d: got v=%b ar=%b id=%0d d=%h want 1 0 11 0f0ff0f0",
                 i, rvalid, arready, rid, rdata);
      end
      tick;
    end
    arvalid = 1'b0; rready = 1'b1; tick; rready = 1'b0;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      errors++;
      $display("FAIL rd_release: got %b want 01", {rvalid, arready});
    end
  endtask

  task automatic test_wait_cycles;
    b_awadr = 32'h44; b_awid = 4'd9; b_awvalid = 1'b1;
    b_wrdata = 32'hCAFEF00D; b_wstrb = 4'hF; b_wvalid = 1'b1;
    tick;
    b_awvalid = 1'b0; b_wvalid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if ({b_bvalid, b_awready, b_wready} !== 3'b000) begin
        errors++;
        $display("FAIL wait_b%0d: got %b want 000",
                 i, {b_bvalid, b_awready, b_wready});
      end
      tick;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({b_bvalid, b_bid, b_bresp, b_awready} !==
          {1'b1, 4'd9, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL wait_hold%0d: got v=%b id=%0d r=%b aw=%b want 1 9 00 0",
                 i, b_bvalid, b_bid, b_bresp, b_awready);
      end
      tick;
    end
    b_bready = 1'b1; tick; b_bready = 1'b0;
    checks++;
    if ({b_bvalid, b_awready} !== 2'b01) begin
      errors++;
      $display("FAIL wait_done: got %b want 01", {b_bvalid, b_awready});
    end
    b_araddr = 32'h4; b_arid = 4'd3; b_arvalid = 1'b1;
    tick;
    b_arvalid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (b_rvalid !== 1'b0) begin
        errors++; $display("FAIL wait_r%0d: got %b want 0", i, b_rvalid);
      end
      tick;
    end
    checks++;
    if ({b_rvalid, b_rdata, b_rresp, b_rid} !==
        {1'b1, 32'hCAFEF00D, 2'b00, 4'd3}) begin
      errors++;
      $display("FAIL alias_read: got v=%b d=%h r=%b id=%0d want 1 cafef00d 00 3",
               b_rvalid, b_rdata, b_rresp, b_rid);
    end
    b_rready = 1'b1; tick; b_rready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] od; logic [1:0] orsp; logic ol; logic [3:0] oid; int lat;
    logic [31:0] addrs [3];
    addrs[0] = 32'h8; addrs[1] = 32'hC; addrs[2] = 32'h3C;
    awadr = 32'h8; awid = 4'd5; awvalid = 1'b1;
    tick;
    awvalid = 1'b0;
    areset = 1'b1;
    tick;
    areset = 1'b0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst: got %b want 000", {awready, wready, bvalid});
    end
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({awready, wready, bvalid} !== 3'b110) begin
        errors++;
        $display("FAIL mid_rst_idle%0d: got %b want 110",
                 i, {awready, wready, bvalid});
      end
      tick;
    end
    foreach (addrs[i]) begin
      axi_read(addrs[i], 4'd0, od, orsp, ol, oid, lat);
      checks++;
      if ({lat, od} !== {32'd1, 32'h0}) begin
        errors++;
        $display("FAIL mem_cleared %h: got lat=%0d d=%h want 1 0",
                 addrs[i], lat, od);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_aw_w_same;
    test_w_before_aw;
    test_aw_before_w;
    test_slverr;
    test_same_cycle_rw;
    test_back_to_back;
    test_wait_cycles;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_bfm_slave_axi4.md
PERIPHERAL_BFM_SLAVE_AXI4 -- requirements
Module: peripheral_bfm_slave_axi4

Interface
REQ-001 Parameter MEM_WORDS, default 16, number of 32-bit words in the internal register file (power of 2, 2..256).
REQ-002 Parameter WAIT_CYCLES, default 0, idle cycles inserted before asserting bvalid/rvalid (0..15).
REQ-003 Parameter ERR_EN, default 1; 1 = out-of-range addresses return SLVERR (2'b10); 0 = alias modulo MEM_WORDS and return OKAY.
REQ-004 aclk  in  1  sole clock; all logic on rising edge.
REQ-005 areset  in  1  synchronous, active-high reset.
REQ-006 awid  in  4  write address ID.
REQ-007 awadr  in  32  write byte address; bits [1:0] ignored.
REQ-008 awvalid  in  1  write address valid.
REQ-009 awready  out  1  write address ready.
REQ-010 wrdata  in  32  write data.
REQ-011 wstrb  in  4  byte strobes; bit n enables byte n.
REQ-012 wlast  in  1  last beat; single-beat only, value not checked.
REQ-013 wvalid  in  1  write data valid.
REQ-014 wready  out  1  write data ready.
REQ-015 bid  out  4  response ID, equals captured awid.
REQ-016 bresp  out  2  OKAY 2'b00 or SLVERR 2'b10.
REQ-017 bvalid  out  1  write response valid.
REQ-018 bready  in  1  write response ready.
REQ-019 arid  in  4  read address ID.
REQ-020 araddr  in  32  read byte address; bits [1:0] ignored.
REQ-021 arvalid  in  1  read address valid.
REQ-022 arready  out  1  read address ready.
REQ-023 rid  out  4  read ID, equals captured arid.
REQ-024 rdata  out  32  read data; 32'h0 when not rvalid or on SLVERR.
REQ-025 rresp  out  2  OKAY or SLVERR.
REQ-026 rlast  out  1  equals rvalid (single beat).
REQ-027 rvalid  out  1  read data valid.
REQ-028 rready  in  1  read data ready.

Function
REQ-029 Write FSM states: W_IDLE, W_ADDR (addr held, awaiting data), W_DATA (data held, awaiting addr), W_WAIT, W_RESP.
REQ-030 W_IDLE: awready=wready=1; AW-only handshake -> W_ADDR; W-only -> W_DATA; both same cycle -> W_WAIT (or W_RESP if WAIT_CYCLES=0).
REQ-031 W_ADDR: awready=0, wready=1; W_DATA: wready=0, awready=1; completing handshake -> W_WAIT/W_RESP.
REQ-032 Memory write occurs on the cycle both address and data are held, byte lanes per wstrb; SLVERR writes modify nothing.
REQ-033 W_WAIT counts WAIT_CYCLES cycles, then W_RESP asserts bvalid; bvalid, bid, bresp stable until bvalid&&bready, then -> W_IDLE.
REQ-034 Read FSM states: R_IDLE (arready=1), R_WAIT, R_RESP; arvalid&&arready captures arid/araddr and memory word.
REQ-035 rvalid asserted WAIT_CYCLES+1 cycles after AR handshake; rid/rdata/rresp/rlast stable until rvalid&&rready, then -> R_IDLE.
REQ-036 Minimum latency with WAIT_CYCLES=0: bvalid/rvalid in cycle after final handshake.
REQ-037 Word index = addr[log2(MEM_WORDS)+1:2]; out of range when addr[31:log2(MEM_WORDS)+2] != 0.
REQ-038 Read and write FSMs independent; same-word read and write completing in same cycle: read returns pre-write value.
REQ-039 One outstanding transaction per channel; no new AW/W/AR accepted while respective response pending.

Reset
REQ-040 While areset=1 at a clock edge: both FSMs to IDLE, wait counters 0, bvalid=rvalid=rlast=0, bresp=rresp=2'b00, bid=rid=0, rdata=0, awready=wready=arready=0.
REQ-041 awready/wready/arready rise to 1 on the first edge after areset deasserts; memory contents reset to 0; reset mid-transaction discards it with no response.

Verification
REQ-042 AW and W same cycle, awadr=0x8, wrdata=0xDEADBEEF, wstrb=4'hF, awid=3 -> bvalid next cycle, bid=3, bresp=00; read 0x8 -> rdata=0xDEADBEEF, rresp=00, rlast=1.
REQ-043 W two cycles before AW, wstrb=4'b0101, wrdata=0x11223344 onto 0xDEADBEEF -> subsequent read 0xDE22BE44.
REQ-044 ERR_EN=1, MEM_WORDS=16, araddr=0x40 -> rresp=10, rdata=0; write to 0x40 -> bresp=10, memory unchanged.
REQ-045 WAIT_CYCLES=3, bready held 0 for 5 cycles -> bvalid rises 4 cycles after handshake, bid/bresp stable until bready, awready=0 throughout.
REQ-046 areset pulsed while in W_ADDR -> no bvalid; post-reset read of any address returns 0x00000000.
